// File: rtl/cpu_fetch_ctrl_pkg.sv
// Shared fetch-stage constants, FSM state encoding and redirect event codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_fetch_ctrl_pkg;

    // Instruction placed in insn_q whenever a slot is annulled or before the first fetch
    localparam logic [15:0] CPU_NOP_INSN = 16'hE000;

    // Default reset and interrupt entry vectors
    localparam logic [15:0] CPU_RST_VEC  = 16'h0000;
    localparam logic [15:0] CPU_IRQ_VEC  = 16'h0010;

    // Fetch sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        FETCH_S_BOOT = 2'd0,
        FETCH_S_RUN  = 2'd1,
        FETCH_S_ISR  = 2'd2
    } fetch_state_t;

    // What the stage does on the coming edge, already priority-resolved
    typedef enum logic [2:0] {
        EV_HOLD = 3'd0,
        EV_SEQ  = 3'd1,
        EV_BR   = 3'd2,
        EV_RETI = 3'd3,
        EV_IRQ  = 3'd4
    } fetch_ev_t;

    // True for the events that discard the fetched word and redirect the PC
    function automatic logic is_redirect(input fetch_ev_t ev);
        return (ev == EV_BR) || (ev == EV_RETI) || (ev == EV_IRQ);
    endfunction

endpackage

// File: rtl/cpu_fetch_redirect.sv
// Priority mux picking the stage event (branch > reti > irq > sequential) and next fetch PC.
// Latency: purely combinational.
// Backpressure: with ce low the event is HOLD and the PC is unchanged.
module cpu_fetch_redirect
    import cpu_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(CPU_IRQ_VEC),
    parameter int                PC_INC  = 1
) (
    input  logic              ce,
    input  fetch_state_t      state,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic [ADDR_W-1:0] ret_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              reti,
    input  logic              irq,
    output fetch_ev_t         ev,
    output logic [ADDR_W-1:0] next_pc,
    output logic              annul
);

    // Resolve the single winning event; reti only counts inside an ISR, irq only outside
    always_comb begin
        ev      = EV_HOLD;
        next_pc = fetch_pc;
        annul   = 1'b0;
        if (ce) begin
            if (br_taken) begin
                ev      = EV_BR;
                next_pc = br_target;
            end else if (reti && (state == FETCH_S_ISR)) begin
                ev      = EV_RETI;
                next_pc = ret_pc;
            end else if (irq && (state == FETCH_S_RUN)) begin
                ev      = EV_IRQ;
                next_pc = IRQ_VEC;
            end else begin
                ev      = EV_SEQ;
                next_pc = fetch_pc + ADDR_W'(PC_INC);
            end
            annul = is_redirect(ev);
        end
    end

endmodule

// File: rtl/cpu_fetch_ctrl.sv
// Fetch-stage sequencer: owns fetch PC and insn_q, annuls one slot per branch/irq/reti redirect.
// Latency: one ce from a redirect edge to the first target instruction in insn_q.
// Backpressure: i_stall or !i_imem_rdy drops o_insn_ce and freezes every register.
module cpu_fetch_ctrl
    import cpu_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                INSN_W  = 16,
    parameter logic [ADDR_W-1:0] RST_VEC = ADDR_W'(CPU_RST_VEC),
    parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(CPU_IRQ_VEC),
    parameter int                PC_INC  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [INSN_W-1:0] i_insn,
    input  logic              i_imem_rdy,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_stall,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    input  logic              i_irq,
    input  logic              i_reti,
    output logic [INSN_W-1:0] o_insn_q,
    output logic              o_insn_vld,
    output logic [ADDR_W-1:0] o_pc_q,
    output logic              o_insn_ce,
    output logic              o_in_irq,
    output logic [ADDR_W-1:0] o_ret_pc,
    output logic              o_annul
);

    localparam logic [INSN_W-1:0] NOP = INSN_W'(CPU_NOP_INSN);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    fetch_ev_t         ev;
    logic              ce;
    logic              redir_annul;
    logic [ADDR_W-1:0] next_pc;

    logic [ADDR_W-1:0] fetch_pc;
    logic [INSN_W-1:0] insn_q;
    logic              insn_vld;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] ret_pc;
    logic              annul_q;

    assign ce = (state != FETCH_S_BOOT) & i_imem_rdy & ~i_stall;

    cpu_fetch_redirect #(
        .ADDR_W  (ADDR_W),
        .IRQ_VEC (IRQ_VEC),
        .PC_INC  (PC_INC)
    ) u_redirect (
        .ce        (ce),
        .state     (state),
        .fetch_pc  (fetch_pc),
        .ret_pc    (ret_pc),
        .br_taken  (i_br_taken),
        .br_target (i_br_target),
        .reti      (i_reti),
        .irq       (i_irq),
        .ev        (ev),
        .next_pc   (next_pc),
        .annul     (redir_annul)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FETCH_S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: boot lasts one cycle; irq enters the ISR, reti leaves it; a branch keeps the state
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH_S_BOOT: state_nxt = FETCH_S_RUN;
            FETCH_S_RUN:  if (ev == EV_IRQ)  state_nxt = FETCH_S_ISR;
            FETCH_S_ISR:  if (ev == EV_RETI) state_nxt = FETCH_S_RUN;
            default:      state_nxt = FETCH_S_BOOT;
        endcase
    end

    // Fetch/issue registers: advance, annul or hold according to the resolved event
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc <= RST_VEC;
            insn_q   <= NOP;
            insn_vld <= 1'b0;
            pc_q     <= '0;
            ret_pc   <= '0;
            annul_q  <= 1'b0;
        end else begin
            annul_q  <= redir_annul;
            fetch_pc <= next_pc;
            case (ev)
                EV_SEQ: begin
                    insn_q   <= i_insn;
                    insn_vld <= 1'b1;
                    pc_q     <= fetch_pc;
                end
                EV_BR, EV_RETI, EV_IRQ: begin
                    // the word at fetch_pc is dropped; pc_q still names it
                    insn_q   <= NOP;
                    insn_vld <= 1'b0;
                    pc_q     <= fetch_pc;
                end
                default: ;
            endcase
            // the discarded word is re-fetched on return
            if (ev == EV_IRQ) begin
                ret_pc <= fetch_pc;
            end
        end
    end

    assign o_imem_addr = fetch_pc;
    assign o_insn_q    = insn_q;
    assign o_insn_vld  = insn_vld;
    assign o_pc_q      = pc_q;
    assign o_insn_ce   = ce;
    assign o_in_irq    = (state == FETCH_S_ISR);
    assign o_ret_pc    = ret_pc;
    assign o_annul     = annul_q;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Self-checking bench for cpu_fetch_ctrl: directed scenarios plus randomized run against a reference model.
// Latency: n/a.
// Backpressure: exercised via random i_stall / i_imem_rdy.
module tb_cpu_fetch_ctrl;
    import cpu_fetch_ctrl_pkg::*;

    localparam logic [15:0] NOP  = CPU_NOP_INSN;
    localparam logic [15:0] IRQV = 16'h0010;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_insn;
    logic        i_imem_rdy;
    logic [15:0] o_imem_addr;
    logic        i_stall;
    logic        i_br_taken;
    logic [15:0] i_br_target;
    logic        i_irq;
    logic        i_reti;
    logic [15:0] o_insn_q;
    logic        o_insn_vld;
    logic [15:0] o_pc_q;
    logic        o_insn_ce;
    logic        o_in_irq;
    logic [15:0] o_ret_pc;
    logic        o_annul;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic        m_booted;
    logic        m_inirq;
    logic [15:0] m_pc;
    logic [15:0] m_insn;
    logic        m_vld;
    logic [15:0] m_pcq;
    logic [15:0] m_ret;
    logic        m_annul;

    always #5 i_clk = ~i_clk;

    // instruction memory contents: never equal to the NOP encoding
    function automatic logic [15:0] mem(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    assign i_insn = mem(o_imem_addr);

    cpu_fetch_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_insn      (i_insn),
        .i_imem_rdy  (i_imem_rdy),
        .o_imem_addr (o_imem_addr),
        .i_stall     (i_stall),
        .i_br_taken  (i_br_taken),
        .i_br_target (i_br_target),
        .i_irq       (i_irq),
        .i_reti      (i_reti),
        .o_insn_q    (o_insn_q),
        .o_insn_vld  (o_insn_vld),
        .o_pc_q      (o_pc_q),
        .o_insn_ce   (o_insn_ce),
        .o_in_irq    (o_in_irq),
        .o_ret_pc    (o_ret_pc),
        .o_annul     (o_annul)
    );

    task automatic model_reset();
        m_booted = 1'b0;
        m_inirq  = 1'b0;
        m_pc     = 16'h0000;
        m_insn   = NOP;
        m_vld    = 1'b0;
        m_pcq    = 16'h0000;
        m_ret    = 16'h0000;
        m_annul  = 1'b0;
    endtask

    function automatic logic model_ce();
        return m_booted && i_imem_rdy && !i_stall;
    endfunction

    // one clock edge of the stage, described from the rules: priority branch > reti > irq > sequential
    task automatic model_edge();
        logic ce;
        ce      = model_ce();
        m_annul = 1'b0;
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (ce) begin
            if (i_br_taken || (i_reti && m_inirq) || (i_irq && !m_inirq)) begin
                m_pcq   = m_pc;
                m_insn  = NOP;
                m_vld   = 1'b0;
                m_annul = 1'b1;
                if (i_br_taken) begin
                    m_pc = i_br_target;
                end else if (i_reti && m_inirq) begin
                    m_pc    = m_ret;
                    m_inirq = 1'b0;
                end else begin
                    m_ret   = m_pc;
                    m_pc    = IRQV;
                    m_inirq = 1'b1;
                end
            end else begin
                m_insn = mem(m_pc);
                m_vld  = 1'b1;
                m_pcq  = m_pc;
                m_pc   = 16'((32'(m_pc) + 1) % 65536);
            end
        end
    endtask

    task automatic idle_inputs();
        i_imem_rdy  = 1'b1;
        i_stall     = 1'b0;
        i_br_taken  = 1'b0;
        i_br_target = 16'h0000;
        i_irq       = 1'b0;
        i_reti      = 1'b0;
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge i_clk);
        #4 i_rst_n = 1'b1;
    endtask

    task automatic branch_to(input logic [15:0] t);
        i_br_taken  = 1'b1;
        i_br_target = t;
        cycle();
        i_br_taken  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (o_insn_q !== NOP) begin bad++; $display("FAIL reset_insn: got %h want %h", o_insn_q, NOP); end
        total++; if (o_imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", o_imem_addr); end
        total++; if (o_insn_ce !== 1'b0) begin bad++; $display("FAIL reset_ce_boot: got %b want 0", o_insn_ce); end
        total++; if ({o_insn_vld, o_in_irq, o_annul} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {o_insn_vld, o_in_irq, o_annul}); end
        total++; if ({o_pc_q, o_ret_pc} !== 32'h0) begin bad++; $display("FAIL reset_pcs: got %h want 0", {o_pc_q, o_ret_pc}); end
        cycle();
        total++; if (o_insn_ce !== 1'b1) begin bad++; $display("FAIL first_ce: got %b want 1", o_insn_ce); end
        total++; if (o_insn_q !== NOP) begin bad++; $display("FAIL boot_hold: got %h want %h", o_insn_q, NOP); end
        cycle();
        total++; if (o_insn_q !== mem(16'h0000)) begin bad++; $display("FAIL first_fetch: got %h want %h", o_insn_q, mem(16'h0000)); end
        total++; if (o_imem_addr !== 16'h0001) begin bad++; $display("FAIL first_inc: got %h want 0001", o_imem_addr); end
    endtask

    task automatic test_branch();
        cycle(); cycle();
        branch_to(16'h0040);
        total++; if (o_insn_q !== NOP || o_annul !== 1'b1 || o_insn_vld !== 1'b0) begin
            bad++; $display("FAIL br_annul: got insn=%h annul=%b vld=%b want %h 1 0", o_insn_q, o_annul, o_insn_vld, NOP); end
        total++; if (o_imem_addr !== 16'h0040) begin bad++; $display("FAIL br_addr: got %h want 0040", o_imem_addr); end
        cycle();
        total++; if (o_insn_q !== mem(16'h0040) || o_pc_q !== 16'h0040) begin
            bad++; $display("FAIL br_target_insn: got %h@%h want %h@0040", o_insn_q, o_pc_q, mem(16'h0040)); end
        total++; if (o_annul !== 1'b0) begin bad++; $display("FAIL br_annul_pulse: got %b want 0", o_annul); end
    endtask

    task automatic test_stall();
        logic [15:0] held_insn;
        logic [15:0] held_pc;
        held_insn   = o_insn_q;
        held_pc     = o_imem_addr;
        i_stall     = 1'b1;
        i_br_taken  = 1'b1;
        i_br_target = 16'h0099;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (o_insn_ce !== 1'b0) begin bad++; $display("FAIL stall_ce[%0d]: got %b want 0", k, o_insn_ce); end
            cycle();
            total++; if (o_insn_q !== held_insn || o_imem_addr !== held_pc || o_annul !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d]: got %h/%h/%b want %h/%h/0", k, o_insn_q, o_imem_addr, o_annul, held_insn, held_pc); end
        end
        i_stall = 1'b0;
        cycle();
        i_br_taken = 1'b0;
        total++; if (o_imem_addr !== 16'h0099 || o_annul !== 1'b1) begin
            bad++; $display("FAIL stall_release_br: got %h annul=%b want 0099 1", o_imem_addr, o_annul); end
    endtask

    task automatic test_irq();
        branch_to(16'h0023);
        i_irq = 1'b1;
        cycle();
        total++; if (o_ret_pc !== 16'h0023 || o_imem_addr !== IRQV) begin
            bad++; $display("FAIL irq_entry: got ret=%h addr=%h want 0023 %h", o_ret_pc, o_imem_addr, IRQV); end
        total++; if (o_in_irq !== 1'b1 || o_annul !== 1'b1) begin
            bad++; $display("FAIL irq_flags: got in_irq=%b annul=%b want 1 1", o_in_irq, o_annul); end
        cycle();
        total++; if (o_imem_addr !== 16'h0011 || o_annul !== 1'b0 || o_ret_pc !== 16'h0023 || o_insn_q !== mem(IRQV)) begin
            bad++; $display("FAIL irq_no_reentry: got addr=%h annul=%b ret=%h insn=%h", o_imem_addr, o_annul, o_ret_pc, o_insn_q); end
        i_irq  = 1'b0;
        i_reti = 1'b1;
        cycle();
        i_reti = 1'b0;
        total++; if (o_imem_addr !== 16'h0023 || o_in_irq !== 1'b0 || o_annul !== 1'b1) begin
            bad++; $display("FAIL reti: got addr=%h in_irq=%b annul=%b want 0023 0 1", o_imem_addr, o_in_irq, o_annul); end
        cycle();
        total++; if (o_insn_q !== mem(16'h0023)) begin bad++; $display("FAIL reti_refetch: got %h want %h", o_insn_q, mem(16'h0023)); end
    endtask

    task automatic test_br_in_isr();
        i_irq = 1'b1;
        cycle();
        i_irq = 1'b0;
        branch_to(16'h0050);
        total++; if (o_annul !== 1'b1 || o_in_irq !== 1'b1 || o_imem_addr !== 16'h0050) begin
            bad++; $display("FAIL isr_branch: got annul=%b in_irq=%b addr=%h want 1 1 0050", o_annul, o_in_irq, o_imem_addr); end
        i_reti = 1'b1;
        cycle();
        i_reti = 1'b0;
        // branch and irq together: branch first, irq at the next ce
        i_irq = 1'b1;
        branch_to(16'h0080);
        total++; if (o_imem_addr !== 16'h0080 || o_in_irq !== 1'b0) begin
            bad++; $display("FAIL br_beats_irq: got addr=%h in_irq=%b want 0080 0", o_imem_addr, o_in_irq); end
        cycle();
        i_irq = 1'b0;
        total++; if (o_in_irq !== 1'b1 || o_ret_pc !== 16'h0080 || o_imem_addr !== IRQV) begin
            bad++; $display("FAIL pending_irq: got in_irq=%b ret=%h addr=%h want 1 0080 %h", o_in_irq, o_ret_pc, o_imem_addr, IRQV); end
        i_reti = 1'b1;
        cycle();
        i_reti = 1'b0;
    endtask

    task automatic test_wrap();
        branch_to(16'hFFFF);
        cycle();
        total++; if (o_imem_addr !== 16'h0000 || o_pc_q !== 16'hFFFF || o_insn_q !== mem(16'hFFFF)) begin
            bad++; $display("FAIL wrap: got addr=%h pc_q=%h insn=%h want 0000 ffff %h", o_imem_addr, o_pc_q, o_insn_q, mem(16'hFFFF)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            i_imem_rdy  = ($urandom_range(0, 3) != 0);
            i_stall     = ($urandom_range(0, 3) == 0);
            i_br_taken  = ($urandom_range(0, 7) == 0);
            i_br_target = 16'($urandom);
            i_irq       = ($urandom_range(0, 5) == 0);
            i_reti      = ($urandom_range(0, 5) == 0);
            #1;
            total++; if (o_insn_ce !== model_ce()) begin bad++; $display("FAIL rnd_ce[%0d]: got %b want %b", n, o_insn_ce, model_ce()); end
            cycle();
            total++; if (o_imem_addr !== m_pc || o_insn_q !== m_insn || o_insn_vld !== m_vld || o_pc_q !== m_pcq) begin
                bad++; $display("FAIL rnd_stage[%0d]: got addr=%h insn=%h vld=%b pcq=%h want %h %h %b %h",
                                n, o_imem_addr, o_insn_q, o_insn_vld, o_pc_q, m_pc, m_insn, m_vld, m_pcq); end
            total++; if (o_in_irq !== m_inirq || o_ret_pc !== m_ret || o_annul !== m_annul) begin
                bad++; $display("FAIL rnd_ctl[%0d]: got in_irq=%b ret=%h annul=%b want %b %h %b",
                                n, o_in_irq, o_ret_pc, o_annul, m_inirq, m_ret, m_annul); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_isr();
        i_irq = 1'b1;
        cycle();
        i_irq   = 1'b0;
        i_stall = 1'b1;
        cycle();
        total++; if (o_in_irq !== 1'b1) begin bad++; $display("FAIL pre_reset_isr: got %b want 1", o_in_irq); end
        #2 i_rst_n = 1'b0;
        #1;
        total++; if (o_in_irq !== 1'b0 || o_insn_q !== NOP || o_imem_addr !== 16'h0000 || o_ret_pc !== 16'h0000) begin
            bad++; $display("FAIL async_reset: got in_irq=%b insn=%h addr=%h ret=%h want 0 %h 0000 0000", o_in_irq, o_insn_q, o_imem_addr, o_ret_pc, NOP); end
        do_reset();
        cycle();
        total++; if (o_insn_ce !== 1'b1 || o_in_irq !== 1'b0) begin bad++; $display("FAIL post_reset: got ce=%b in_irq=%b want 1 0", o_insn_ce, o_in_irq); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_irq();
        test_br_in_isr();
        test_wrap();
        test_random();
        test_reset_mid_isr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_ctrl.md
Name: cpu_fetch_ctrl

Overview:
- Fetch-stage sequencer for the soc CPU. Owns the fetch PC and the fetch/execute instruction register (insn_q).
- Decides each cycle whether insn_q loads the fetched word, holds, or is annulled to `CPU_NOP_INSN`. Annul happens on a taken branch, on interrupt entry, or on return-from-interrupt.
- Sits between instruction memory and the execute stage. Provides the insn_ce / br_taken / in_irq view that soc-level branch-annul monitors check.

Parameters:
- ADDR_W, 16, fetch address width.
- INSN_W, 16, instruction width.
- RST_VEC, 16'h0000, first fetch address after reset.
- IRQ_VEC, 16'h0010, interrupt entry address.
- PC_INC, 1, fetch PC increment per consumed word (word addressing).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_insn  in  INSN_W  instruction word at o_imem_addr.
- i_imem_rdy  in  1  i_insn valid this cycle.
- o_imem_addr  out  ADDR_W  fetch PC.
- i_stall  in  1  execute hazard; freeze the stage.
- i_br_taken  in  1  execute resolved a taken branch.
- i_br_target  in  ADDR_W  branch destination.
- i_irq  in  1  level interrupt request.
- i_reti  in  1  execute retiring return-from-interrupt.
- o_insn_q  out  INSN_W  instruction presented to execute.
- o_insn_vld  out  1  o_insn_q is a real fetched instruction (0 = annul or boot NOP).
- o_pc_q  out  ADDR_W  address associated with o_insn_q.
- o_insn_ce  out  1  stage advance strobe.
- o_in_irq  out  1  ISR in progress.
- o_ret_pc  out  ADDR_W  saved return address.
- o_annul  out  1  one-cycle pulse: insn_q was annulled on the last edge.

Behaviour:
- Reset is asynchronous and active-low (i_rst_n), single clock i_clk.
- Reset values:
  - fetch PC = RST_VEC.
  - insn_q = `CPU_NOP_INSN`.
  - insn_vld = 0, pc_q = 0, in_irq = 0, ret_pc = 0, annul = 0.
  - state = S_BOOT.
- FSM states: S_BOOT, S_RUN, S_ISR.
  - S_BOOT → S_RUN unconditionally after one cycle. o_insn_ce = 0 in S_BOOT.
  - S_RUN → S_ISR on irq entry.
  - S_ISR → S_RUN on reti.
  - o_in_irq = (state == S_ISR).
- o_insn_ce = (state != S_BOOT) & i_imem_rdy & ~i_stall. When ce = 0, every register holds and o_annul = 0.
- Event priority, evaluated only when ce = 1: branch > reti > irq > sequential.
  - Branch (i_br_taken):
    - fetch PC <= i_br_target.
    - insn_q <= NOP, insn_vld <= 0, annul <= 1.
    - State unchanged, so a branch inside an ISR keeps in_irq = 1.
  - Reti (i_reti, only in S_ISR):
    - fetch PC <= ret_pc.
    - insn_q <= NOP, annul <= 1.
    - state <= S_RUN.
    - i_reti in S_RUN is ignored and treated as sequential.
  - Irq (i_irq, only in S_RUN, no branch or reti this cycle):
    - ret_pc <= current fetch PC; that word is discarded and re-fetched on return.
    - fetch PC <= IRQ_VEC.
    - insn_q <= NOP, annul <= 1.
    - state <= S_ISR.
  - Sequential:
    - insn_q <= i_insn, insn_vld <= 1, pc_q <= fetch PC.
    - fetch PC <= fetch PC + PC_INC, wrapping modulo 2^ADDR_W (16'hFFFF → 16'h0000).
- On every annul, pc_q <= the discarded fetch PC.
- Exactly one annulled slot per redirect; latency from redirect edge to the first target instruction in insn_q is one ce.
- An irq that is pending while a branch or reti wins is taken at the next ce. After reti, irq may enter at the very next ce; no re-entry while in S_ISR.
- Simultaneous i_br_taken and i_reti is a protocol error; the branch wins and the state is unchanged.
- i_br_taken with ce = 0 has no effect; execute holds it until ce.
- Reset asserted mid-ISR or mid-stall returns immediately to the reset values above.

Decomposition:
- Shared constants header (constants.vh): `CPU_NOP_INSN`, RST/IRQ vector defaults, and FSM state encodings `FETCH_S_BOOT/RUN/ISR` (2-bit).
- No sub-module required. Optional sub-module cpu_fetch_redirect: the combinational priority mux producing next-PC and the annul decision.

Test Plan:
- Reset release, i_imem_rdy = 1:
  - Cycle 1: insn_q = NOP, o_imem_addr = 0x0000, insn_ce = 0.
  - Cycle 2: insn_ce = 1.
  - Next edge: insn_q = mem[0x0000], o_imem_addr = 0x0001.
- Branch at ce, target 0x0040:
  - Next cycle: insn_q = NOP, o_annul = 1, insn_vld = 0, o_imem_addr = 0x0040.
  - Following ce: insn_q = mem[0x0040], pc_q = 0x0040.
- i_stall = 1 for 3 cycles with i_br_taken held:
  - insn_ce = 0 and insn_q/PC unchanged for all 3 cycles.
  - Redirect to target on the first cycle after stall drops.
- i_irq = 1 at fetch PC 0x0023:
  - ret_pc = 0x0023, o_imem_addr = 0x0010, in_irq = 1, annul pulse.
  - A second i_irq is ignored.
  - i_reti: o_imem_addr = 0x0023, in_irq = 0, annul pulse.
- Branch inside ISR: annul occurs and in_irq stays 1. Simultaneous br (0x0080) + irq: branch first, then irq at the next ce with ret_pc = 0x0080.
- Fetch PC 0xFFFF sequential: wraps to 0x0000. Assert i_rst_n = 0 mid-ISR: in_irq = 0 and insn_q = NOP immediately, without waiting for a clock edge.
